// File: rtl/rsa_pkg.sv
// +-----------------------------------------------------------------------------+
// | rsa_pkg                                                                     |
// | Shared types for the modular-exponentiation job sequencer.                  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package rsa_pkg;

  localparam int JOB_WORD_W = 32;
  localparam int JOB_E_W    = 17;
  localparam int JOB_ID_W   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENG_RST = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    OUT     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_MOD     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef struct packed {
    logic [JOB_WORD_W-1:0] x;
    logic [JOB_E_W-1:0]    e;
    logic [JOB_WORD_W-1:0] m;
    logic [JOB_ID_W-1:0]   id;
  } job_t;

endpackage

`default_nettype wire

// File: rtl/rsa_exp_sequencer.sv
// +-----------------------------------------------------------------------------+
// | rsa_exp_sequencer                                                           |
// | Screens x^e mod m jobs and drives the exponentiation engine handshake.      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int WORD_WIDTH     = JOB_WORD_W,
  parameter int E_WIDTH        = JOB_E_W,
  parameter int ID_WIDTH       = JOB_ID_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_x,
  input  logic [E_WIDTH-1:0]    in_e,
  input  logic [WORD_WIDTH-1:0] in_m,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  eng_reset,
  output logic                  eng_enable,
  output logic [WORD_WIDTH-1:0] eng_x,
  output logic [WORD_WIDTH-1:0] eng_m,
  output logic [E_WIDTH-1:0]    eng_e,
  output logic [WORD_WIDTH:0]   eng_R,
  input  logic                  eng_done,
  input  logic [WORD_WIDTH-1:0] eng_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_result,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [1:0]            out_err,
  output logic [15:0]           cnt_ok,
  output logic [15:0]           cnt_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  job_t                  job_q, job_d;
  logic [WORD_WIDTH-1:0] result_q, result_d;
  err_e                  err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [15:0]           cnt_ok_q, cnt_ok_d;
  logic [15:0]           cnt_err_q, cnt_err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  eng_reset_q, eng_reset_d;
  logic                  eng_enable_q, eng_enable_d;

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    result_d  = result_q;
    err_d     = err_q;
    timer_d   = timer_q;
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          job_d.x  = in_x;
          job_d.e  = in_e;
          job_d.m  = in_m;
          job_d.id = in_id;
          // An even modulus (including zero) has no Montgomery form.
          if (!in_m[0]) begin
            state_d  = OUT;
            err_d    = ERR_MOD;
            result_d = '0;
          end else if (in_e == '0) begin
            state_d  = OUT;
            err_d    = ERR_NONE;
            result_d = (in_m == WORD_WIDTH'(1)) ? '0 : WORD_WIDTH'(1);
          end else begin
            state_d = ENG_RST;
          end
        end
      end
      ENG_RST: state_d = START;
      START: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (eng_done) begin
          state_d  = OUT;
          err_d    = ERR_NONE;
          result_d = eng_result;
        end else if (timer_q == TMR_LAST) begin
          state_d  = OUT;
          err_d    = ERR_TIMEOUT;
          result_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          if (err_q == ERR_NONE) begin
            if (cnt_ok_q != 16'hFFFF) cnt_ok_d = cnt_ok_q + 16'd1;
          end else begin
            if (cnt_err_q != 16'hFFFF) cnt_err_d = cnt_err_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d   = (state_d == IDLE);
    out_valid_d  = (state_d == OUT);
    eng_reset_d  = (state_d == ENG_RST);
    eng_enable_d = (state_d == START);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      job_q        <= '0;
      result_q     <= '0;
      err_q        <= ERR_NONE;
      timer_q      <= '0;
      cnt_ok_q     <= '0;
      cnt_err_q    <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      eng_reset_q  <= 1'b0;
      eng_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      result_q     <= result_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
      cnt_ok_q     <= cnt_ok_d;
      cnt_err_q    <= cnt_err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      eng_reset_q  <= eng_reset_d;
      eng_enable_q <= eng_enable_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign eng_reset  = eng_reset_q;
  assign eng_enable = eng_enable_q;
  assign eng_x      = job_q.x;
  assign eng_e      = job_q.e;
  assign eng_m      = job_q.m;
  assign eng_R      = {1'b1, {WORD_WIDTH{1'b0}}};
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_id     = job_q.id;
  assign out_err    = err_q;
  assign cnt_ok     = cnt_ok_q;
  assign cnt_err    = cnt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_exp_sequencer.sv
// +-----------------------------------------------------------------------------+
// | tb_rsa_exp_sequencer                                                        |
// | Scoreboard bench for rsa_exp_sequencer with a behavioural engine partner.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rsa_exp_sequencer;
  import rsa_pkg::*;

  localparam int WW      = 32;
  localparam int EW      = 17;
  localparam int IW      = 4;
  localparam int TO      = 64;
  localparam int ENG_LAT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [WW-1:0] in_m = '0;
  logic [IW-1:0] in_id = '0;
  logic          eng_reset, eng_enable;
  logic [WW-1:0] eng_x, eng_m;
  logic [EW-1:0] eng_e;
  logic [WW:0]   eng_R;
  logic          eng_done;
  logic [WW-1:0] eng_result;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_result;
  logic [IW-1:0] out_id;
  logic [1:0]    out_err;
  logic [15:0]   cnt_ok, cnt_err;

  rsa_exp_sequencer #(.WORD_WIDTH(WW), .E_WIDTH(EW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_id(in_id),
    .eng_reset(eng_reset), .eng_enable(eng_enable),
    .eng_x(eng_x), .eng_m(eng_m), .eng_e(eng_e), .eng_R(eng_R),
    .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_id(out_id), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] res;
    logic [IW-1:0] id;
    logic [1:0]    err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0, hs_cyc = 0, ov_cyc = 0, rst_cyc = 0, en_cyc = 0;
  int   rst_cnt = 0, en_cnt = 0;
  int   n_exp_ok = 0, n_exp_err = 0;
  logic ov_prev = 1'b0;
  logic stall_engine = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] modexp(input logic [WW-1:0] x, input logic [EW-1:0] e,
                                           input logic [WW-1:0] m);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1;
    b = {32'd0, x} % {32'd0, m};
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * b) % {32'd0, m};
      b = (b * b) % {32'd0, m};
    end
    return r[WW-1:0];
  endfunction

  // Engine partner: soft clear, start pulse, result after a fixed latency, done held.
  int eng_timer;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_done   <= 1'b0;
      eng_result <= '0;
      eng_timer  <= -1;
    end else if (eng_reset) begin
      eng_done  <= 1'b0;
      eng_timer <= -1;
    end else if (eng_enable) begin
      eng_timer <= ENG_LAT;
    end else if (eng_timer > 0) begin
      eng_timer <= eng_timer - 1;
    end else if (eng_timer == 0) begin
      if (!stall_engine) begin
        eng_done   <= 1'b1;
        eng_result <= modexp(eng_x, eng_e, eng_m);
      end
      eng_timer <= -1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t t;
    if (!reset) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (eng_reset) begin rst_cnt++; rst_cyc = cyc; end
      if (eng_enable) begin en_cnt++; en_cyc = cyc; end
      if (out_valid && !ov_prev) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("out_result", out_result, t.res);
          check("out_id", out_id, t.id);
          check("out_err", out_err, t.err);
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic drive_job(input logic [WW-1:0] x, input logic [EW-1:0] e, input logic [WW-1:0] m,
                           input logic [IW-1:0] id, input logic [WW-1:0] res, input logic [1:0] err);
    exp_t t;
    t.res = res; t.id = id; t.err = err;
    sb.push_back(t);
    if (err == 2'd0) n_exp_ok++; else n_exp_err++;
    in_x = x; in_e = e; in_m = m; in_id = id;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (k >= 200) begin check("accept_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [WW-1:0] x, input logic [EW-1:0] e, input logic [WW-1:0] m,
                          input logic [IW-1:0] id, input logic [WW-1:0] res, input logic [1:0] err);
    drive_job(x, e, m, id, res, err);
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; ; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
      if (k >= 400) begin check("drain_timeout", 64'd0, 64'd1); break; end
    end
  endtask

  task automatic check_cnt();
    check("cnt_ok", cnt_ok, n_exp_ok);
    check("cnt_err", cnt_err, n_exp_err);
  endtask

  int r0, e0;

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_eng_reset", eng_reset, 0);
    check("rst_eng_enable", eng_enable, 0);
    check("rst_eng_x", eng_x, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cnt_ok", cnt_ok, 0);
    check("eng_R", eng_R, 64'h1_0000_0000);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    r0 = rst_cnt; e0 = en_cnt;
    send_job(32'd5, 17'd3, 32'd13, 4'd3, 32'd8, 2'd0);
    check("lat_eng_x", eng_x, 5);
    check("lat_eng_e", eng_e, 3);
    check("lat_eng_m", eng_m, 13);
    drain();
    check("j1_rst_pulses", rst_cnt - r0, 1);
    check("j1_en_pulses", en_cnt - e0, 1);
    check("j1_rst_cycle", rst_cyc - acc_cyc, 1);
    check("j1_en_cycle", en_cyc - acc_cyc, 2);
    check_cnt();

    send_job(32'd2, 17'd10, 32'd1000003, 4'd1, 32'd1024, 2'd0);
    drain();
    send_job(32'd7, 17'd65537, 32'd3233, 4'd2, 32'd2369, 2'd0);
    drain();
    check_cnt();

    e0 = en_cnt;
    send_job(32'd5, 17'd3, 32'd12, 4'd4, 32'd0, 2'd1);
    drain();
    check("err_out_latency", ov_cyc - acc_cyc, 1);
    check_cnt();
    send_job(32'd9, 17'd0, 32'd7, 4'd6, 32'd1, 2'd0);
    drain();
    check("bypass_out_latency", ov_cyc - acc_cyc, 1);
    send_job(32'd9, 17'd0, 32'd1, 4'd9, 32'd0, 2'd0);
    drain();
    send_job(32'd3, 17'd3, 32'd0, 4'd10, 32'd0, 2'd1);
    drain();
    check("no_enable_bypass", en_cnt - e0, 0);
    check_cnt();

    stall_engine = 1'b1;
    send_job(32'd4, 17'd5, 32'd21, 4'd7, 32'd0, 2'd2);
    drain();
    check("timeout_latency", ov_cyc - (en_cyc + 1), TO);
    stall_engine = 1'b0;
    check_cnt();
    send_job(32'd5, 17'd3, 32'd13, 4'd8, 32'd8, 2'd0);
    drain();
    check_cnt();

    out_ready = 1'b0;
    send_job(32'd2, 17'd0, 32'd9, 4'd5, 32'd1, 2'd0);
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (k >= 50) begin check("bp_valid_timeout", 64'd0, 64'd1); break; end
    end
    drive_job(32'd5, 17'd3, 32'd13, 4'd11, 32'd8, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 1);
      check("bp_id", out_id, 5);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    check("bp_accept_after_hs", acc_cyc - hs_cyc, 1);
    drain();
    check_cnt();

    stall_engine = 1'b1;
    e0 = en_cnt;
    send_job(32'd6, 17'd5, 32'd15, 4'd12, 32'd0, 2'd2);
    for (int k = 0; ; k++) begin
      @(posedge clk); #1;
      if (en_cnt != e0) break;
      if (k >= 50) begin check("wait_entry_timeout", 64'd0, 64'd1); break; end
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_eng_enable", eng_enable, 0);
    check("arst_eng_reset", eng_reset, 0);
    check("arst_eng_x", eng_x, 0);
    check("arst_out_result", out_result, 0);
    check("arst_cnt_ok", cnt_ok, 0);
    check("arst_cnt_err", cnt_err, 0);
    sb.delete();
    n_exp_ok = 0;
    n_exp_err = 0;
    stall_engine = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send_job(32'd3, 17'd4, 32'd11, 4'd13, 32'd4, 2'd0);
    drain();
    check_cnt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/rsa_exp_sequencer.md
Name: rsa_exp_sequencer

Overview:
Initiator-side controller for the montgomery_exp engine. It accepts modular-exponentiation jobs (x, e, m, tag) on a valid/ready input, screens them, and sequences the engine's soft-reset/enable/done protocol. It returns result, tag and error code on a valid/ready output. It sits between the RSA command path and the exponentiation engine, replacing testbench-style driving with synthesizable control.

Parameters:
WORD_WIDTH, 32, operand/modulus/result width
E_WIDTH, 17, exponent width
ID_WIDTH, 4, job tag width
TIMEOUT_CYCLES, 4096, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
in_valid  in  1  job offered
in_ready  out  1  job accepted when in_valid&in_ready
in_x  in  WORD_WIDTH  base
in_e  in  E_WIDTH  exponent
in_m  in  WORD_WIDTH  modulus
in_id  in  ID_WIDTH  job tag
eng_reset  out  1  engine soft clear; integrator ORs with global reset
eng_enable  out  1  engine start pulse
eng_x, eng_m  out  WORD_WIDTH  registered operands
eng_e  out  E_WIDTH  registered exponent
eng_R  out  WORD_WIDTH+1  constant 1<<WORD_WIDTH
eng_done  in  1  engine level done
eng_result  in  WORD_WIDTH  engine result
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_result  out  WORD_WIDTH  x^e mod m, or 0 on error
out_id  out  ID_WIDTH  echoed tag
out_err  out  2  0 ok, 1 bad modulus, 2 timeout
cnt_ok, cnt_err  out  16  saturating job counters

Behaviour:
- All outputs are registered. On reset: state IDLE; in_ready=1; eng_reset=0; eng_enable=0; out_valid=0; operand/result/id/err regs=0; counters=0. Reset mid-job aborts it silently with no output and no counter update.
- FSM: IDLE -> ENG_RST -> START -> WAIT -> OUT -> IDLE. Error/bypass jobs go IDLE -> OUT.
- IDLE: in_ready=1. On accept, latch x, e, m, id.
  - m even or m==0: next OUT with err=1, result=0. Engine untouched.
  - e==0: next OUT with err=0, result=(m==1)?0:1. Engine untouched.
  - Otherwise: next ENG_RST.
- ENG_RST: eng_reset=1 for exactly one cycle.
- START: eng_enable=1 for exactly one cycle.
- WAIT: a timer counts from 0.
  - eng_done=1: capture eng_result, err=0, go OUT.
  - Timer reaches TIMEOUT_CYCLES-1 without done: err=2, result=0, go OUT.
  - If done and expiry occur in the same cycle, done wins.
- eng_done is ignored in every state except WAIT.
- in_ready=0 outside IDLE, so only one job is in flight.
- OUT: out_valid=1. result/id/err are held stable while out_ready=0. On out_valid&out_ready: out_valid=0 next cycle, counter update, go IDLE. A new job is accepted no earlier than the cycle after the handshake.
- Counters: cnt_ok increments on err==0, cnt_err otherwise. Both saturate at 16'hFFFF.
- Latency:
  - Bypass/error job accepted at cycle T gives out_valid at T+1.
  - Engine job gives eng_reset at T+1, eng_enable at T+2, WAIT from T+3, out_valid the cycle after eng_done is sampled.
- eng_x/eng_e/eng_m hold the latched values from accept until the next accept.

Decomposition:
- Package rsa_pkg: typedef of the state enum (IDLE, ENG_RST, START, WAIT, OUT), err code enum (ERR_NONE=0, ERR_MOD=1, ERR_TIMEOUT=2), and the typedef for the job struct {x, e, m, id}.
- No sub-module is required. The engine is instantiated beside this block at integration level. In the bench, montgomery_exp is the DUT's engine partner.

Test Plan:
- Job x=5, e=3, m=13, id=3, out_ready=1 -> out_result=8, out_id=3, out_err=0; exactly one eng_enable pulse preceded by one eng_reset pulse; cnt_ok=1.
- Job x=2, e=10, m=1000003 -> out_result=1024, err=0. Then x=7, e=65537, m=3233 -> result matches the Python golden model.
- Job m=12 -> out_valid one cycle after accept, err=1, result=0, eng_enable never asserted; cnt_err=1. Then e=0, m=7 -> result=1, no enable.
- Engine stub holds eng_done=0 with TIMEOUT_CYCLES=64 -> out_err=2 exactly 64 cycles after WAIT entry, result=0. Next valid job completes normally.
- out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0, second in_valid job not accepted until one cycle after the handshake.
- Assert reset during WAIT -> all outputs return to reset values asynchronously, no out_valid, counters=0. A subsequent job x=3, e=4, m=11 -> result=4.
